im_fetch_unit: RTL and testbench
================================

// Module: im_fetch_unit
// PURPOSE
//   Instruction fetch stage directly downstream of the instruction memory (IM).
//   Owns the PC and issues word reads to IM (1-cycle synchronous read). Buffers
//   returned words with their PC in a prefetch FIFO and hands them to decode
//   over a valid/ready handshake. Branch/jump redirects flush buffered and
//   in-flight fetches.
// PARAMETERS
//   ADDRWIDTH   16  IM word-address width; PC width
//   DATAWIDTH   32  instruction width
//   FIFO_DEPTH  4   prefetch entries; power of 2, >=2
//   RESET_PC    0   PC (word address) loaded on reset
// PORTS
//   clk            in   1          clock, rising edge
//   rst            in   1          asynchronous, active-low reset
//   fetch_en       in   1          1 = issue new reads; 0 = stop issuing, drain
//   redirect_valid in   1          flush and restart at redirect_pc
//   redirect_pc    in   ADDRWIDTH  new PC (word address)
//   inst_valid     out  1          inst_out/inst_pc hold a valid instruction
//   inst_ready     in   1          decode accepts; pop when inst_valid & inst_ready
//   inst_out       out  DATAWIDTH  instruction word at FIFO head
//   inst_pc        out  ADDRWIDTH  word address of inst_out
//   IM_enable      out  1          IM access strobe
//   IM_write       out  1          tied 0 (read-only master)
//   IM_in          out  DATAWIDTH  tied 0
//   IM_address     out  ADDRWIDTH  IM word address
//   IM_out         in   DATAWIDTH  IM read data, valid the cycle after IM_enable
// BEHAVIOUR
//   - Reset (rst=0, async): pc=RESET_PC, FIFO empty, no read pending,
//     inst_valid=0, inst_out=0, inst_pc=0, IM_enable=0, IM_address=RESET_PC.
//     Reset mid-operation discards all pending/buffered state immediately.
//   - Issue (cycle N): IM_enable=1 iff (fetch_en | redirect_valid) and
//     count + rsp_pending < FIFO_DEPTH; count is pre-pop (no same-cycle credit).
//     IM_address = redirect_valid ? redirect_pc : pc. On issue pc <= addr+1.
//   - Response: rsp_pending, rsp_pc registered at issue; in cycle N+1 IM_out
//     pushed with rsp_pc unless killed. inst_valid rises in cycle N+2.
//     Sustained throughput 1 instr/cycle with inst_ready held 1.
//   - PC wrap: 2^ADDRWIDTH-1 + 1 -> 0, no error.
//   - FIFO: registered head; simultaneous push+pop allowed at any occupancy;
//     credit rule guarantees no overflow; pop while empty ignored.
//   - Redirect (cycle R): FIFO cleared; response returning in R is dropped;
//     inst_valid forced 0 in R, so no pop in R; the read at redirect_pc is
//     issued in R (credit counts as empty). First redirected instr valid R+2.
//     Redirect ignores fetch_en for that single issue.
//   - fetch_en=0: no new issue; pending response still pushed; FIFO drains.
//   - inst_out/inst_pc stable while inst_valid & !inst_ready (except redirect).
// CONFIGURATION
//   FETCH_PERF_EN defined: adds ports
//     fetch_count out 32  # accepted instrs (inst_valid & inst_ready)
//     flush_count out 16  # redirect cycles
//     Both reset to 0, saturate at all-ones, never wrap.
//   Not defined: ports and counters absent; otherwise identical behaviour.
// TESTING
//   1 Reset, RESET_PC=0, fetch_en=1, ready=1, IM[0..3]=A0..A3 -> valid at
//     cycle 2, then A0..A3 with pc 0,1,2,3 on consecutive cycles.
//   2 ready=0 from reset, fetch_en=1 -> exactly 4 IM reads (addr 0..3), FIFO
//     full, IM_enable 0; ready=1 -> A0..A3 in order, reads resume at addr 4.
//   3 Streaming at pc 5, redirect_valid 1 cycle with redirect_pc=0x0100 ->
//     IM_address=0x0100 in R, no old instr after R, inst_pc=0x0100 at R+2.
//   4 Redirect to 0xFFFE, ready=1 -> inst_pc 0xFFFE,0xFFFF,0x0000,0x0001.
//   5 Streaming, assert rst=0 mid-cycle -> inst_valid, IM_enable drop
//     immediately; release -> refetch from RESET_PC, first instr at cycle 2.
//   6 FETCH_PERF_EN: 10 accepts, 3 redirects -> fetch_count=10, flush_count=3;
//     preload flush_count=0xFFFF, redirect -> stays 0xFFFF.

Source files
------------

// File: rtl/im_fetch_if.sv
// im_fetch_if: groups the fetch unit's two buses into one bundle.
//   - Decode side: inst_valid / inst_ready handshake carrying inst_out and
//     inst_pc. A transfer happens on every rising clock edge where
//     inst_valid & inst_ready are both 1. While inst_valid is 1 and
//     inst_ready is 0, inst_out/inst_pc hold their value. The only exception
//     is a redirect, which withdraws the instruction.
//   - IM side: IM_enable / IM_address read strobe. IM_out is returned one
//     cycle later. IM_write and IM_in are tied to 0.
// Modports:
//   master : the fetch unit (drives inst_*, IM_enable/IM_write/IM_in/IM_address)
//   slave  : decode + instruction memory (drives inst_ready, IM_out)
interface im_fetch_if #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
);
  logic                 inst_valid;
  logic                 inst_ready;
  logic [DATAWIDTH-1:0] inst_out;
  logic [ADDRWIDTH-1:0] inst_pc;
  logic                 IM_enable;
  logic                 IM_write;
  logic [DATAWIDTH-1:0] IM_in;
  logic [ADDRWIDTH-1:0] IM_address;
  logic [DATAWIDTH-1:0] IM_out;

  modport master (
    output inst_valid, inst_out, inst_pc,
    output IM_enable, IM_write, IM_in, IM_address,
    input  inst_ready, IM_out
  );

  modport slave (
    input  inst_valid, inst_out, inst_pc,
    input  IM_enable, IM_write, IM_in, IM_address,
    output inst_ready, IM_out
  );
endinterface

// File: rtl/im_fetch_unit.sv
// im_fetch_unit: instruction fetch stage placed in front of a 1-cycle
// synchronous instruction memory.
// This block owns the PC and issues one word read per cycle. Each returned
// word is buffered together with its PC in a prefetch FIFO, and the FIFO head
// is handed to decode. A redirect flushes all buffered fetches and the fetch
// that is still in flight.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   fetch_en       1 = issue new reads, 0 = stop issuing and let the FIFO drain
//   redirect_valid flush and restart fetching at redirect_pc
//   redirect_pc    new PC (word address)
//   bus            im_fetch_if.master (decode handshake and IM read port)
//   fetch_count    (FETCH_PERF_EN only) count of accepted instructions,
//                  saturating
//   flush_count    (FETCH_PERF_EN only) count of redirect cycles, saturating
// Build option: define FETCH_PERF_EN to add the two performance counters.
module im_fetch_unit #(
  parameter int                   ADDRWIDTH  = 16,
  parameter int                   DATAWIDTH  = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [ADDRWIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc,
  im_fetch_if.master           bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [15:0]          flush_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRWIDTH-1:0] pc;
  logic                 rsp_pending;
  logic [ADDRWIDTH-1:0] rsp_pc;
  logic [DATAWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDRWIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                 credit_ok;
  logic                 issue;
  logic [ADDRWIDTH-1:0] issue_addr;
  logic                 push;
  logic                 pop;
  logic                 has_data;

  // Credit covers the FIFO entries plus the read still in flight. The count
  // used here is taken before any pop in the same cycle, so a pop does not
  // free a slot until the following cycle. A redirect empties everything,
  // so its single issue is always allowed, even when fetch_en is 0.
  always_comb begin
    credit_ok  = (count + CW'(rsp_pending)) < CW'(FIFO_DEPTH);
    issue      = rst & (redirect_valid | (fetch_en & credit_ok));
    issue_addr = redirect_valid ? redirect_pc : pc;
    // A response that returns during the redirect cycle belongs to the old
    // stream, so it is dropped.
    push       = rsp_pending & ~redirect_valid;
    has_data   = (count != '0);
    pop        = has_data & ~redirect_valid & bus.inst_ready;
  end

  assign bus.IM_enable  = issue;
  assign bus.IM_address = issue_addr;
  assign bus.IM_write   = 1'b0;
  assign bus.IM_in      = '0;
  assign bus.inst_valid = has_data & ~redirect_valid;
  assign bus.inst_out   = has_data ? fifo_data[rd_ptr] : '0;
  assign bus.inst_pc    = has_data ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      rsp_pending <= 1'b0;
      rsp_pc      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      rsp_pending <= issue;
      if (issue) begin
        pc     <= issue_addr + ADDRWIDTH'(1);  // wraps from all-ones to 0
        rsp_pc <= issue_addr;
      end
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // The storage array needs no reset. Its outputs are masked whenever the
  // FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.IM_out;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (pop && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (redirect_valid && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_im_fetch_unit.sv
// Testbench for im_fetch_unit. This bench uses the default parameters
// (16-bit PC, 32-bit words, FIFO depth 4, reset PC 0).
// The bench contains a behavioural instruction memory. A scoreboard holds
// the PCs expected at the decode port, and each accepted instruction is
// checked against that queue.
module tb_im_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  im_fetch_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) bus ();

  im_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run  = 0;
  int fails      = 0;
  int accept_cnt = 0;
  logic        rd_log = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] rd_q[$];

  function automatic logic [31:0] im_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // Instruction memory model: one-cycle synchronous read.
  always @(posedge clk)
    if (bus.IM_enable) bus.IM_out <= im_word(bus.IM_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expected PC for every accepted instruction.
  always @(negedge clk) begin
    if (bus.inst_valid && bus.inst_ready) begin
      accept_cnt++;
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $error("FAIL unexpected_accept pc=%0h expected no instruction", bus.inst_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("acc_pc", 32'(bus.inst_pc), 32'(e));
        chk("acc_data", bus.inst_out, im_word(e));
      end
    end
  end

  // IM read log.
  always @(negedge clk)
    if (rd_log && bus.IM_enable) rd_q.push_back(bus.IM_address);

  initial begin
    bus.IM_out     = '0;
    bus.inst_ready = 1'b0;
    rst            = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    chk("rst_im_enable", 32'(bus.IM_enable), 32'd0);
    chk("rst_im_address", 32'(bus.IM_address), 32'd0);
    chk("rst_im_write", 32'(bus.IM_write), 32'd0);
    chk("rst_im_in", bus.IM_in, 32'd0);

    // Test 1: streaming from reset. The first instruction is valid in cycle 2.
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
    fetch_en = 1'b1; bus.inst_ready = 1'b1; rst = 1'b1;    // cycle 0
    @(negedge clk);
    chk("c0_im_enable", 32'(bus.IM_enable), 32'd1);
    chk("c0_im_address", 32'(bus.IM_address), 32'd0);
    chk("c0_inst_valid", 32'(bus.inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("c1_inst_valid", 32'(bus.inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("c2_inst_valid", 32'(bus.inst_valid), 32'd1);
    repeat (5) step();                                      // cycle 7

    // Test 3: redirect to 0x0100 while streaming.
    chk("pre_redirect_accepts", 32'(accept_cnt), 32'd5);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0100 + 16'(i));
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    chk("r_im_enable", 32'(bus.IM_enable), 32'd1);
    chk("r_im_address", 32'(bus.IM_address), 32'h0100);
    chk("r_inst_valid", 32'(bus.inst_valid), 32'd0);
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("r1_inst_valid", 32'(bus.inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("r2_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("r2_inst_pc", 32'(bus.inst_pc), 32'h0100);
    repeat (4) step();

    // Test 4: redirect near the top of the address space, so the PC wraps.
    chk("sb_empty_t3", 32'(exp_q.size()), 32'd0);
    chk("accepts_t3", 32'(accept_cnt), 32'd9);
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    chk("r_wrap_address", 32'(bus.IM_address), 32'hFFFE);
    step(); redirect_valid = 1'b0;
    repeat (5) step();

    // Test 5: asynchronous reset while streaming, then refetch from PC 0.
    chk("sb_empty_t4", 32'(exp_q.size()), 32'd0);
    chk("accepts_t4", 32'(accept_cnt), 32'd13);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_rst_im_enable", 32'(bus.IM_enable), 32'd0);
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    rst = 1'b1;                                             // cycle 0
    @(negedge clk);
    chk("t5_c0_im_enable", 32'(bus.IM_enable), 32'd1);
    step(); @(negedge clk);
    chk("t5_c1_inst_valid", 32'(bus.inst_valid), 32'd0);
    step(); @(negedge clk);
    chk("t5_c2_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("t5_c2_inst_pc", 32'(bus.inst_pc), 32'd0);
    repeat (4) step();
    chk("sb_empty_t5", 32'(exp_q.size()), 32'd0);
    chk("accepts_t5", 32'(accept_cnt), 32'd17);

    // Test 2: decode stalled from reset. The FIFO fills, issue stops, then
    // decode drains the FIFO.
    rst = 1'b0; bus.inst_ready = 1'b0; exp_q.delete();
    step();
    rd_q.delete(); rd_log = 1'b1; rst = 1'b1;               // cycle 0
    repeat (8) step();
    @(negedge clk);
    chk("full_reads", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("full_read_addr", 32'(rd_q[i]), 32'(i));
    chk("full_im_enable", 32'(bus.IM_enable), 32'd0);
    chk("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("stall_inst_pc", 32'(bus.inst_pc), 32'd0);
    chk("stall_inst_out", bus.inst_out, im_word(16'd0));
    for (int i = 0; i < 9; i++) exp_q.push_back(16'(i));
    step(); bus.inst_ready = 1'b1;                          // cycle k
    @(negedge clk);
    chk("k_im_enable", 32'(bus.IM_enable), 32'd0);
    step(); @(negedge clk);
    chk("k1_im_enable", 32'(bus.IM_enable), 32'd1);
    chk("k1_im_address", 32'(bus.IM_address), 32'd4);
    repeat (5) step();
    fetch_en = 1'b0;                                        // drain
    repeat (8) step();
    @(negedge clk);
    chk("drain_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("drain_im_enable", 32'(bus.IM_enable), 32'd0);
    chk("drain_reads", 32'(rd_q.size()), 32'd9);
    chk("sb_empty_t2", 32'(exp_q.size()), 32'd0);
    chk("accepts_t2", 32'(accept_cnt), 32'd26);
    rd_log = 1'b0;

`ifdef FETCH_PERF_EN
    // Test 6: performance counters and saturation.
    step(); rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
    fetch_en = 1'b1; bus.inst_ready = 1'b1; rst = 1'b1;     // cycle 0
    repeat (12) step();
    bus.inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    repeat (3) step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("perf_fetch_count", fetch_count, 32'd10);
    chk("perf_flush_count", 32'(flush_count), 32'd3);
    redirect_valid = 1'b1;
    repeat (65535) step();
    @(negedge clk);
    chk("perf_flush_sat", 32'(flush_count), 32'hFFFF);
    step(); @(negedge clk);
    chk("perf_flush_hold", 32'(flush_count), 32'hFFFF);
    redirect_valid = 1'b0;
    chk("sb_empty_t6", 32'(exp_q.size()), 32'd0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
